// File: rtl/register_file_dumper_pkg.sv
// Shared types and defaults for the register file dumper.
// Pure declarations: no latency or flow control of its own.
package register_file_dumper_pkg;

    localparam int DATA_WIDTH_DEFAULT    = 8;
    localparam int POINTER_WIDTH_DEFAULT = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_SEND,
        ST_CSUM,
        ST_DONE
    } state_e;

endpackage

// File: rtl/register_file_dumper_if.sv
// Byte stream from the dumper to its sink, valid/ready handshake.
// Master holds data/last while valid and not ready; the slave drives out_ready.
interface register_file_dumper_if
    import register_file_dumper_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
);
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/register_file_dumper_stream_out_reg.sv
// Output holding register: load captures data/last and raises valid next cycle.
// Contents stay stable until the handshake, which clears valid on the following edge.
module stream_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    logic                  valid_d, valid_q;
    logic [DATA_WIDTH-1:0] data_d,  data_q;
    logic                  last_d,  last_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        last_d  = last_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            last_d  = load_last;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_last  = last_q;
endmodule

// File: rtl/register_file_dumper.sv
// Walks the register file on start and streams each register as one byte, 2 cycles/byte.
// Holds on backpressure with no timeout; REGISTER_FILE_DUMPER_CHECKSUM_EN appends an XOR byte.
module register_file_dumper
    import register_file_dumper_pkg::*;
#(
    parameter int POINTER_WIDTH = POINTER_WIDTH_DEFAULT,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    output logic [POINTER_WIDTH-1:0] rf_address,
    output logic                     rf_is_immediate,
    output logic                     rf_write_enable,
    input  logic [DATA_WIDTH-1:0]    rf_data,
    output logic                     busy,
    output logic                     done,
    register_file_dumper_if.master   out_if
);
    localparam int                     NUM_REGS = 2 ** POINTER_WIDTH;
    localparam logic [POINTER_WIDTH-1:0] LAST_IDX = POINTER_WIDTH'(NUM_REGS - 1);

    state_e                   state_d, state_q;
    logic [POINTER_WIDTH-1:0] index_d, index_q;
    logic                     load;
    logic [DATA_WIDTH-1:0]    load_data;
    logic                     load_last;
    logic                     handshake;

    assign handshake = out_if.out_valid & out_if.out_ready;

`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] checksum_d, checksum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        load      = 1'b0;
        load_data = rf_data;
        load_last = 1'b0;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
        checksum_d = checksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_READ;
                    index_d = '0;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
                    checksum_d = '0;
`endif
                end
            end
            ST_READ: begin
                load    = 1'b1;
                state_d = ST_SEND;
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
                checksum_d = checksum_q ^ rf_data;
`else
                load_last  = (index_q == LAST_IDX);
`endif
            end
            ST_SEND: begin
                if (handshake) begin
                    if (index_q != LAST_IDX) begin
                        index_d = index_q + 1'b1;
                        state_d = ST_READ;
                    end else begin
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
            ST_CSUM: begin
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
                // First CSUM cycle loads the checksum byte, then waits for its handshake.
                if (!out_if.out_valid) begin
                    load      = 1'b1;
                    load_data = checksum_q;
                    load_last = 1'b1;
                end else if (handshake) begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
        end
    end

    stream_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_stream_out_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .load_data (load_data),
        .load_last (load_last),
        .out_ready (out_if.out_ready),
        .out_valid (out_if.out_valid),
        .out_data  (out_if.out_data),
        .out_last  (out_if.out_last)
    );

    assign rf_address      = index_q;
    assign rf_is_immediate = 1'b0;
    assign rf_write_enable = 1'b0;
    assign busy            = (state_q == ST_READ) || (state_q == ST_SEND) || (state_q == ST_CSUM);
    assign done            = (state_q == ST_DONE);
endmodule

// File: tb/tb_register_file_dumper.sv
// Directed bench for register_file_dumper: ordering, backpressure, restart, reset abort, live writes.
module tb_register_file_dumper;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [2:0] rf_address;
    logic       rf_is_immediate;
    logic       rf_write_enable;
    logic [7:0] rf_data;
    logic       busy;
    logic       done;

    logic [7:0] regs [8];
    assign rf_data = regs[rf_address];

    register_file_dumper_if #(.DATA_WIDTH(8)) sif ();

    register_file_dumper #(
        .POINTER_WIDTH (3),
        .DATA_WIDTH    (8)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .rf_address      (rf_address),
        .rf_is_immediate (rf_is_immediate),
        .rf_write_enable (rf_write_enable),
        .rf_data         (rf_data),
        .busy            (busy),
        .done            (done),
        .out_if          (sif)
    );

    always #5 clock = ~clock;

`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
    localparam int EXP_N    = 9;
    localparam int EXP_DONE = 19;
`else
    localparam int EXP_N    = 8;
    localparam int EXP_DONE = 17;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] cap_data [16];
    logic       cap_last [16];
    int cap_n = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    int first_vld_cyc = -1;

    always @(posedge clock) cyc++;

    // Handshakes are recorded mid-cycle; they complete at the following rising edge.
    always @(negedge clock) begin
        if (reset === 1'b0) begin
            if (sif.out_valid === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (sif.out_valid === 1'b1 && sif.out_ready === 1'b1) begin
                if (cap_n < 16) begin
                    cap_data[cap_n] = sif.out_data;
                    cap_last[cap_n] = sif.out_last;
                end
                cap_n++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_capture();
        cap_n = 0;
        done_cnt = 0;
        done_cyc = -1;
        first_vld_cyc = -1;
    endtask

    task automatic preload_seq();
        for (int i = 0; i < 8; i++) regs[i] = 8'(8'h10 + i);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done_wait: done not seen within %0d cycles", name, budget);
        end
    endtask

    task automatic wait_byte(input logic [7:0] val, input int budget, input string name);
        int n = 0;
        while (!(sif.out_valid === 1'b1 && sif.out_data === val) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (!(sif.out_valid === 1'b1 && sif.out_data === val)) begin
            errors++;
            $display("FAIL %s_byte_wait: byte %h not presented within %0d cycles", name, val, budget);
        end
    endtask

    task automatic check_seq(input string name);
        checks++;
        if (cap_n !== EXP_N) begin
            errors++;
            $display("FAIL %s_count: got %0d bytes, want %0d", name, cap_n, EXP_N);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap_data[i] !== 8'(8'h10 + i)) begin
                errors++;
                $display("FAIL %s_byte%0d: got %h, want %h", name, i, cap_data[i], 8'(8'h10 + i));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sif.out_ready = 1'b1;
        step();
        step();
        checks++;
        if (rf_address !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: addr=%0d busy=%b done=%b, want 0 0 0", rf_address, busy, done);
        end
        checks++;
        if (sif.out_valid !== 1'b0 || sif.out_data !== 8'h00 || sif.out_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_stream: vld=%b dat=%h last=%b, want 0 00 0",
                     sif.out_valid, sif.out_data, sif.out_last);
        end
        checks++;
        if (rf_is_immediate !== 1'b0 || rf_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_rf_ctrl: imm=%b we=%b, want 0 0", rf_is_immediate, rf_write_enable);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        int s;
        logic exp_last;
        preload_seq();
        sif.out_ready = 1'b1;
        clear_capture();
        s = cyc;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || rf_address !== 3'd0) begin
            errors++;
            $display("FAIL basic_read_state: busy=%b addr=%0d, want 1 0", busy, rf_address);
        end
        wait_done(80, "basic");
        step();
        step();
        check_seq("basic");
        for (int i = 0; i < 8; i++) begin
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
            exp_last = 1'b0;
`else
            exp_last = (i == 7);
`endif
            checks++;
            if (cap_last[i] !== exp_last) begin
                errors++;
                $display("FAIL basic_last%0d: got %b, want %b", i, cap_last[i], exp_last);
            end
        end
        checks++;
        if (first_vld_cyc !== s + 2) begin
            errors++;
            $display("FAIL basic_first_valid: at +%0d, want +2", first_vld_cyc - s);
        end
        checks++;
        if (done_cyc !== s + EXP_DONE || done_cnt !== 1) begin
            errors++;
            $display("FAIL basic_done_timing: at +%0d count %0d, want +%0d count 1",
                     done_cyc - s, done_cnt, EXP_DONE);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_busy: got %b, want 0", busy);
        end
    endtask

    task automatic test_stall();
        preload_seq();
        sif.out_ready = 1'b1;
        clear_capture();
        pulse_start();
        wait_byte(8'h13, 40, "stall");
        sif.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (sif.out_valid !== 1'b1 || sif.out_data !== 8'h13 || sif.out_last !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: vld=%b dat=%h last=%b, want 1 13 0",
                         i, sif.out_valid, sif.out_data, sif.out_last);
            end
            step();
        end
        sif.out_ready = 1'b1;
        wait_done(80, "stall");
        step();
        check_seq("stall");
    endtask

    task automatic test_back_to_back_start();
        int n = 0;
        preload_seq();
        sif.out_ready = 1'b1;
        clear_capture();
        pulse_start();
        repeat (4) step();
        pulse_start();
        repeat (3) step();
        pulse_start();
        while (done !== 1'b1 && n < 80) begin
            step();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done_wait: done not seen within 80 cycles");
        end
        pulse_start();
        checks++;
        if (busy !== 1'b0 || sif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_start_in_done: busy=%b vld=%b, want 0 0", busy, sif.out_valid);
        end
        step();
        step();
        checks++;
        if (busy !== 1'b0 || done_cnt !== 1) begin
            errors++;
            $display("FAIL restart_single_done: busy=%b done_count=%0d, want 0 1", busy, done_cnt);
        end
        check_seq("restart");
    endtask

    task automatic test_reset_mid_dump();
        preload_seq();
        sif.out_ready = 1'b1;
        clear_capture();
        pulse_start();
        wait_byte(8'h14, 40, "rstmid");
        reset = 1'b1;
        step();
        checks++;
        if (sif.out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || rf_address !== 3'd0) begin
            errors++;
            $display("FAIL rstmid_abort: vld=%b busy=%b done=%b addr=%0d, want 0 0 0 0",
                     sif.out_valid, busy, done, rf_address);
        end
        reset = 1'b0;
        repeat (3) step();
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0 || cap_n !== 4) begin
            errors++;
            $display("FAIL rstmid_no_done: done_count=%0d busy=%b bytes=%0d, want 0 0 4",
                     done_cnt, busy, cap_n);
        end
        clear_capture();
        pulse_start();
        wait_done(80, "rstmid_restart");
        step();
        check_seq("rstmid_restart");
    endtask

    task automatic test_write_during_dump();
        preload_seq();
        sif.out_ready = 1'b1;
        clear_capture();
        pulse_start();
        wait_byte(8'h12, 40, "live");
        regs[6] = 8'hAA;
        wait_done(80, "live");
        step();
        checks++;
        if (cap_data[6] !== 8'hAA) begin
            errors++;
            $display("FAIL live_byte6: got %h, want aa", cap_data[6]);
        end
        checks++;
        if (cap_data[5] !== 8'h15 || cap_data[7] !== 8'h17 || cap_n !== EXP_N) begin
            errors++;
            $display("FAIL live_neighbours: b5=%h b7=%h n=%0d, want 15 17 %0d",
                     cap_data[5], cap_data[7], cap_n, EXP_N);
        end
    endtask

`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
    task automatic test_checksum();
        for (int i = 0; i < 8; i++) regs[i] = 8'(1 << i);
        sif.out_ready = 1'b1;
        clear_capture();
        pulse_start();
        wait_done(80, "csum");
        step();
        checks++;
        if (cap_n !== 9 || cap_data[8] !== 8'hFF || cap_last[8] !== 1'b1) begin
            errors++;
            $display("FAIL csum_byte: n=%0d dat=%h last=%b, want 9 ff 1", cap_n, cap_data[8], cap_last[8]);
        end
        checks++;
        if (cap_data[7] !== 8'h80 || cap_last[7] !== 1'b0) begin
            errors++;
            $display("FAIL csum_reg7: dat=%h last=%b, want 80 0", cap_data[7], cap_last[7]);
        end
    endtask
`endif

    initial begin
        sif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) regs[i] = 8'h00;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back_start();
        test_reset_mid_dump();
        test_write_during_dump();
`ifdef REGISTER_FILE_DUMPER_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
